// File: rtl/ram8_arbiter.sv
//==============================================================================
// Module  : ram8_arbiter
// Purpose : Round-robin sharing of one RAM8 (8 x 16) between requesters A and B,
//           plus a bulk-clear walk. Optional stall counters: RAM8_ARB_STATS_EN.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module ram8_arbiter #(
    parameter logic [15:0] CLEAR_VALUE = 16'h0000,
    parameter bit          FIRST_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [2:0]  a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [2:0]  b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [15:0] b_rdata,
    input  logic        clear_start,
    output logic        busy,
`ifdef RAM8_ARB_STATS_EN
    output logic [7:0]  a_stall_cnt,
    output logic [7:0]  b_stall_cnt,
`endif
    output logic [15:0] ram_in,
    output logic        ram_load,
    output logic [2:0]  ram_address,
    input  logic [15:0] ram_out
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic        r_rr_ptr;
    logic [2:0]  r_cnt;
    logic        r_a_rvalid;
    logic        r_b_rvalid;
    logic [15:0] r_a_rdata;
    logic [15:0] r_b_rdata;
    logic        w_arb_ok;

    // State register plus the datapath registers it governs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= FIRST_PRIO;
            r_cnt      <= 3'd0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= 16'h0000;
            r_b_rdata  <= 16'h0000;
        end else begin
            r_state    <= w_state_nxt;
            r_a_rvalid <= a_gnt & ~a_we;
            r_b_rvalid <= b_gnt & ~b_we;
            if (a_gnt && !a_we) r_a_rdata <= ram_out;
            if (b_gnt && !b_we) r_b_rdata <= ram_out;
            if (a_gnt)      r_rr_ptr <= 1'b1;
            else if (b_gnt) r_rr_ptr <= 1'b0;
            if (r_state == S_CLEAR) r_cnt <= r_cnt + 3'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clear_start)   w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_cnt == 3'd7) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // clear_start pre-empts arbitration in the cycle it is seen
    assign w_arb_ok = (r_state == S_IDLE) & ~reset & ~clear_start;

    always_comb begin
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;
        busy        = 1'b0;
        ram_load    = 1'b0;
        ram_in      = a_wdata;
        ram_address = a_addr;
        if (r_state == S_CLEAR) begin
            busy        = 1'b1;
            ram_load    = ~reset;
            ram_in      = CLEAR_VALUE;
            ram_address = r_cnt;
        end else begin
            a_gnt = w_arb_ok & a_req & (~b_req | ~r_rr_ptr);
            b_gnt = w_arb_ok & b_req & (~a_req |  r_rr_ptr);
            if (b_gnt) begin
                ram_in      = b_wdata;
                ram_address = b_addr;
            end
            ram_load = (a_gnt & a_we) | (b_gnt & b_we);
        end
    end

    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign a_rdata  = r_a_rdata;
    assign b_rdata  = r_b_rdata;

`ifdef RAM8_ARB_STATS_EN
    logic [7:0] r_a_stall;
    logic [7:0] r_b_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_stall <= 8'h00;
            r_b_stall <= 8'h00;
        end else begin
            if (a_req && !a_gnt && r_a_stall != 8'hFF) r_a_stall <= r_a_stall + 8'd1;
            if (b_req && !b_gnt && r_b_stall != 8'hFF) r_b_stall <= r_b_stall + 8'd1;
        end
    end

    assign a_stall_cnt = r_a_stall;
    assign b_stall_cnt = r_b_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram8_arbiter.sv
//==============================================================================
// Module  : tb_ram8_arbiter
// Purpose : Directed self-checking bench for ram8_arbiter with a RAM8 model.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_ram8_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we, clear_start;
    logic [2:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    wire         a_gnt, a_rvalid, b_gnt, b_rvalid, busy, ram_load;
    wire  [15:0] a_rdata, b_rdata, ram_in;
    wire  [2:0]  ram_address;
    wire  [15:0] ram_out;
`ifdef RAM8_ARB_STATS_EN
    wire  [7:0]  a_stall_cnt, b_stall_cnt;
`endif

    logic [15:0] mem [8];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
    assign ram_out = mem[ram_address];

    ram8_arbiter #(.CLEAR_VALUE(16'h0000), .FIRST_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .clear_start(clear_start), .busy(busy),
`ifdef RAM8_ARB_STATS_EN
        .a_stall_cnt(a_stall_cnt), .b_stall_cnt(b_stall_cnt),
`endif
        .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
        .ram_out(ram_out)
    );

    task automatic idle_inputs();
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        clear_start = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; idle_inputs();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic write_a(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = addr; a_wdata = data;
        @(posedge clk); #1;
        a_req = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        a_req = 1; a_we = 1; b_req = 1; b_we = 1;
        @(negedge clk); #1;
        n_vec++; if (a_gnt !== 1'b0) begin n_err++; $display("FAIL rst_a_gnt: got %b want 0", a_gnt); end
        n_vec++; if (b_gnt !== 1'b0) begin n_err++; $display("FAIL rst_b_gnt: got %b want 0", b_gnt); end
        n_vec++; if (ram_load !== 1'b0) begin n_err++; $display("FAIL rst_load: got %b want 0", ram_load); end
        @(posedge clk);
        @(negedge clk);
        reset = 0; idle_inputs(); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if ({a_rvalid, b_rvalid} !== 2'b00) begin n_err++; $display("FAIL rst_rvalid: got %b want 00", {a_rvalid, b_rvalid}); end
        n_vec++; if ({a_rdata, b_rdata} !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", {a_rdata, b_rdata}); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = 3'd3; a_wdata = 16'hBEEF; #1;
        n_vec++; if ({a_gnt, b_gnt} !== 2'b10) begin n_err++; $display("FAIL wr_gnt: got %b want 10", {a_gnt, b_gnt}); end
        n_vec++; if ({ram_load, ram_address, ram_in} !== {1'b1, 3'd3, 16'hBEEF}) begin
            n_err++; $display("FAIL wr_ram: got %b %h %h want 1 3 beef", ram_load, ram_address, ram_in); end
        @(posedge clk); #1;
        n_vec++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_rvalid: got %b want 0", a_rvalid); end
        @(negedge clk);
        a_we = 0; #1;
        n_vec++; if ({a_gnt, b_gnt, ram_load} !== 3'b100) begin n_err++; $display("FAIL rd_gnt: got %b want 100", {a_gnt, b_gnt, ram_load}); end
        @(posedge clk); #1;
        n_vec++; if ({a_rvalid, a_rdata} !== {1'b1, 16'hBEEF}) begin n_err++; $display("FAIL rd_data: got %b %h want 1 beef", a_rvalid, a_rdata); end
        @(negedge clk);
        a_req = 0;
        @(posedge clk); #1;
        n_vec++; if ({a_rvalid, a_rdata} !== {1'b0, 16'hBEEF}) begin n_err++; $display("FAIL rd_hold: got %b %h want 0 beef", a_rvalid, a_rdata); end
    endtask

    task automatic test_round_robin();
        write_a(3'd0, 16'hAAAA);
        write_a(3'd1, 16'h5555);
        do_reset();
        a_req = 1; a_we = 0; a_addr = 3'd0;
        b_req = 1; b_we = 0; b_addr = 3'd1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_vec++; if ({a_gnt, b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, {a_gnt, b_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01); end
            @(posedge clk); #1;
            if (i % 2 == 0) begin
                n_vec++; if ({a_rvalid, b_rvalid, a_rdata} !== {2'b10, 16'hAAAA}) begin
                    n_err++; $display("FAIL rr_a_data[%0d]: got %b%b %h want 10 aaaa", i, a_rvalid, b_rvalid, a_rdata); end
            end else begin
                n_vec++; if ({a_rvalid, b_rvalid, b_rdata} !== {2'b01, 16'h5555}) begin
                    n_err++; $display("FAIL rr_b_data[%0d]: got %b%b %h want 01 5555", i, a_rvalid, b_rvalid, b_rdata); end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_write_read_conflict();
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = 3'd5; a_wdata = 16'h1234;
        b_req = 1; b_we = 0; b_addr = 3'd5; #1;
        n_vec++; if ({a_gnt, b_gnt} !== 2'b10) begin n_err++; $display("FAIL wrc_first: got %b want 10", {a_gnt, b_gnt}); end
        @(posedge clk);
        @(negedge clk);
        a_req = 0; #1;
        n_vec++; if ({b_gnt, ram_address} !== {1'b1, 3'd5}) begin n_err++; $display("FAIL wrc_second: got %b %h want 1 5", b_gnt, ram_address); end
        @(posedge clk); #1;
        n_vec++; if ({b_rvalid, b_rdata} !== {1'b1, 16'h1234}) begin n_err++; $display("FAIL wrc_data: got %b %h want 1 1234", b_rvalid, b_rdata); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 8; i++) write_a(3'(i), 16'h0100 + 16'(i));
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 3'd2; clear_start = 1; #1;
        n_vec++; if ({a_gnt, busy, ram_load} !== 3'b000) begin n_err++; $display("FAIL clr_start: got %b want 000", {a_gnt, busy, ram_load}); end
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            clear_start = (k == 2);
            #1;
            n_vec++; if ({busy, ram_load, a_gnt, ram_address, ram_in} !== {3'b110, 3'(k), 16'h0000}) begin
                n_err++; $display("FAIL clr_walk[%0d]: got %b%b%b %h %h want 110 %0d 0000", k, busy, ram_load, a_gnt, ram_address, ram_in, k); end
            @(posedge clk);
        end
        @(negedge clk);
        clear_start = 0; #1;
        n_vec++; if ({busy, a_gnt} !== 2'b01) begin n_err++; $display("FAIL clr_exit: got %b want 01", {busy, a_gnt}); end
        @(posedge clk); #1;
        n_vec++; if ({a_rvalid, a_rdata} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL clr_pend: got %b %h want 1 0000", a_rvalid, a_rdata); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_addr = 3'(i);
            @(posedge clk); #1;
            n_vec++; if ({a_rvalid, a_rdata} !== {1'b1, 16'h0000}) begin
                n_err++; $display("FAIL clr_read[%0d]: got %b %h want 1 0000", i, a_rvalid, a_rdata); end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_in_clear();
        for (int i = 0; i < 8; i++) write_a(3'(i), 16'h2200 + 16'(i));
        @(negedge clk);
        clear_start = 1;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            clear_start = 0;
            @(posedge clk);
        end
        @(negedge clk); #1;
        n_vec++; if ({busy, ram_address} !== {1'b1, 3'd3}) begin n_err++; $display("FAIL ric_cnt: got %b %h want 1 3", busy, ram_address); end
        reset = 1; #1;
        n_vec++; if (ram_load !== 1'b0) begin n_err++; $display("FAIL ric_load: got %b want 0", ram_load); end
        @(posedge clk);
        @(negedge clk);
        reset = 0; #1;
        n_vec++; if ({busy, ram_load} !== 2'b00) begin n_err++; $display("FAIL ric_busy: got %b want 00", {busy, ram_load}); end
        for (int i = 0; i < 8; i++) begin
            n_vec++; if (mem[i] !== ((i < 3) ? 16'h0000 : 16'h2200 + 16'(i))) begin
                n_err++; $display("FAIL ric_mem[%0d]: got %h want %h", i, mem[i], (i < 3) ? 16'h0000 : 16'h2200 + 16'(i)); end
        end
    endtask

`ifdef RAM8_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        b_req = 1; clear_start = 1;
        repeat (200) @(posedge clk);
        #1;
        n_vec++; if (b_stall_cnt !== 8'd200) begin n_err++; $display("FAIL stat_mid: got %0d want 200", b_stall_cnt); end
        n_vec++; if (a_stall_cnt !== 8'd0) begin n_err++; $display("FAIL stat_a: got %0d want 0", a_stall_cnt); end
        repeat (100) @(posedge clk);
        #1;
        n_vec++; if (b_stall_cnt !== 8'hFF) begin n_err++; $display("FAIL stat_sat: got %h want ff", b_stall_cnt); end
        @(negedge clk);
        idle_inputs();
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 16'h7700 + 16'(i);
        test_reset();
        test_write_read();
        test_round_robin();
        test_write_read_conflict();
        test_clear();
        test_reset_in_clear();
`ifdef RAM8_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram8_arbiter.md
Name: ram8_arbiter

Overview:
- Shares one RAM8 instance (8 x 16-bit words) between two requesters, A (CPU port) and B (debug/DMA port), using round-robin arbitration.
- Also sequences a bulk-clear walk that writes CLEAR_VALUE to all 8 words.
- Sits between the requesters and the RAM8 ports `in`, `load`, `address` and `out`; it is the only block that drives the RAM8 inputs.

Parameters:
- CLEAR_VALUE, 16'h0000, word written to every address during a clear walk.
- FIRST_PRIO, 0, requester favoured after reset (0 = A, 1 = B).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a_req  input  1  A requests a transaction; held stable until granted.
- a_we  input  1  A transaction is a write (1) or a read (0).
- a_addr  input  3  A word address.
- a_wdata  input  16  A write data.
- a_gnt  output  1  A transaction accepted this cycle (combinational).
- a_rvalid  output  1  A read data valid (registered).
- a_rdata  output  16  A read data (registered).
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
- clear_start  input  1  pulse that starts a clear walk.
- busy  output  1  clear walk in progress.
- ram_in  output  16  to RAM8 `in`.
- ram_load  output  1  to RAM8 `load`.
- ram_address  output  3  to RAM8 `address`.
- ram_out  input  16  from RAM8 `out` (combinational read of ram_address).

Behaviour:
- Reset: one clock, reset synchronous and active-high, ports named clk and reset.
  - While reset=1: a_gnt=b_gnt=0 and ram_load=0.
  - After the reset edge: state=IDLE, rr_ptr=FIRST_PRIO, clear counter=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, busy=0.
  - Reset during CLEAR aborts the walk; words already written stay written.
- States: IDLE and CLEAR.
- IDLE, arbitration:
  - Only one requester asserting req gets gnt in the same cycle.
  - Both asserting: grant goes to the requester selected by rr_ptr.
  - On any grant, rr_ptr <= the other requester. rr_ptr is unchanged when nothing is granted.
  - At most one grant per cycle.
  - A transaction completes on the edge where req&gnt=1. A requester not granted keeps req and its fields stable.
- IDLE, RAM drive:
  - ram_address = granted addr (A's addr when idle with no grant).
  - ram_in = granted wdata.
  - ram_load = gnt & we.
  - A write is visible to a read granted in the next cycle (RAM8 registers load on the edge).
- Read latency is 1 cycle:
  - On the edge where a read is granted, x_rdata <= ram_out and x_rvalid <= 1.
  - x_rvalid is 1 for exactly one cycle per read. x_rdata holds its value until the next read for that requester.
  - Writes never assert rvalid.
- IDLE -> CLEAR when clear_start=1.
  - clear_start takes priority over requests in the same cycle: no grant that cycle.
  - An rvalid from a read granted in the previous cycle is still delivered.
- CLEAR:
  - busy=1, ram_load=1, ram_in=CLEAR_VALUE, ram_address=counter. The counter runs 0..7, one word per cycle, for 8 cycles.
  - a_gnt=b_gnt=0 throughout; requests wait.
  - clear_start is ignored during CLEAR.
  - After address 7 is written, go to IDLE with busy=0. The counter wraps to 0. rr_ptr is untouched.
- Address arithmetic: addresses are 3 bits, no bounds checks needed.

Optional Feature:
- Macro: RAM8_ARB_STATS_EN.
- Defined:
  - Adds output ports a_stall_cnt[7:0] and b_stall_cnt[7:0].
  - Each counts cycles where x_req=1 and x_gnt=0, including cycles spent waiting during CLEAR.
  - Counters saturate at 8'hFF and reset to 0.
- Undefined: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset, then A write addr3=16'hBEEF, then A read addr3 -> a_gnt=1 on both cycles; a_rvalid=1 one cycle after the read grant with a_rdata=16'hBEEF; b_gnt stays 0.
- A and B both held requesting reads of addr0/addr1 for 4 cycles after reset with FIRST_PRIO=0 -> grants in order A, B, A, B; each rvalid returns the matching word.
- Same cycle: A writes addr5=16'h1234 and B reads addr5 -> A granted first, B granted next cycle; b_rdata=16'h1234.
- Preload all 8 words, pulse clear_start with a_req=1 pending -> busy=1 for exactly 8 cycles with ram_address 0..7; a_gnt=0 throughout, then a_gnt=1 on the first IDLE cycle; every read returns CLEAR_VALUE.
- Assert reset at clear counter=3 -> busy=0 and state IDLE after the edge; words 0..2 cleared; words 3..7 keep their prior values.
- With RAM8_ARB_STATS_EN: B requests continuously while A is favoured for 300 cycles (e.g. A held in CLEAR-blocked contention) -> b_stall_cnt saturates at 8'hFF and does not wrap.
